// File: rtl/key_pkg.sv
// Shared definitions for the keypad encoder: state encoding, code width and
// the code-to-(row,col) table also used by the scanner-side decoder.
package key_pkg;

    localparam int KEY_CODE_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } key_state_e;

    // Indexed by key code, each entry is {row[1:0], col[1:0]}.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'hD, 4'h0, 4'h1, 4'h2,
        4'h4, 4'h5, 4'h6, 4'h8,
        4'h9, 4'hA, 4'h3, 4'h7,
        4'hB, 4'hF, 4'hC, 4'hE
    };

    function automatic logic [3:0] key_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/key_code_map.sv
// Combinational key code lookup: codes 16-31 are flagged invalid, 0-15 map
// to a (row, col) position in the 4x4 matrix.
module key_code_map
    import key_pkg::*;
(
    input  logic [KEY_CODE_W-1:0] code,
    output logic                  valid,
    output logic [1:0]            row,
    output logic [1:0]            col
);

    logic [3:0] entry;

    assign entry = KEY_MAP[code[3:0]];
    assign valid = ~code[KEY_CODE_W-1];
    assign row   = entry[3:2];
    assign col   = entry[1:0];

endmodule

// File: rtl/encoder_key.sv
// Keypad emulator: holds one key closed for HOLD_CYCLES, then waits GAP_CYCLES.
// Optional key_abort input is enabled with macro ENCODER_KEY_ABORT_EN.
//
// state    | meaning
// ST_IDLE  | ready for a new key request
// ST_PRESS | key closed, columns answer the matching row drive
// ST_GAP   | key released, waiting before the next request is accepted
module encoder_key
    import key_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned GAP_CYCLES  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEY_CODE_W-1:0] key_code,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [3:0]            filas,
`ifdef ENCODER_KEY_ABORT_EN
    input  logic                  key_abort,
`endif
    output logic [3:0]            columnas,
    output logic                  busy,
    output logic                  done,
    output logic                  key_err
);

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

    key_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  row_q, row_d;
    logic [1:0]  col_q, col_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        map_valid;
    logic [1:0]  map_row;
    logic [1:0]  map_col;
    logic        abort;

`ifdef ENCODER_KEY_ABORT_EN
    assign abort = key_abort;
`else
    assign abort = 1'b0;
`endif

    key_code_map u_map (
        .code  (key_code),
        .valid (map_valid),
        .row   (map_row),
        .col   (map_col)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    if (map_valid) begin
                        row_d   = map_row;
                        col_d   = map_col;
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_PRESS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PRESS: begin
                if (abort || cnt_q == 16'd0) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign key_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_PRESS) || (state_q == ST_GAP);
    assign done      = done_q;
    assign key_err   = err_q;

    // Zero-latency path: the scanner samples columns on the falling edge.
    always_comb begin
        columnas = 4'b0000;
        if (state_q == ST_PRESS && filas == key_onehot(row_q))
            columnas = key_onehot(col_q);
    end

endmodule
